// File: rtl/l2_cache_lock_ctrl_if.sv
// Bundles the requester handshake and the LRU access/lock port of the L2 lock controller.
// master: requesters plus L2 pipeline side; slave: the lock controller.
interface l2_cache_lock_ctrl_if #(
    parameter int unsigned NUM_REQUESTERS  = 4,
    parameter int unsigned SET_INDEX_WIDTH = 8,
    parameter int unsigned WAY_INDEX_WIDTH = 2
);
    logic [NUM_REQUESTERS-1:0]                 req_valid;
    logic [NUM_REQUESTERS*SET_INDEX_WIDTH-1:0] req_set;
    logic [NUM_REQUESTERS*WAY_INDEX_WIDTH-1:0] req_way;
    logic [NUM_REQUESTERS-1:0]                 req_lock;
    logic [NUM_REQUESTERS-1:0]                 req_ack;
    logic [NUM_REQUESTERS-1:0]                 req_reject;
    logic                                      init_done;
    logic                                      cache_access_en;
    logic                                      cache_fill_en;
    logic                                      lru_access_en;
    logic [SET_INDEX_WIDTH-1:0]                lru_access_set;
    logic                                      lru_lock_en;
    logic                                      lru_lock_value;
    logic                                      lru_access_update_en;
    logic [WAY_INDEX_WIDTH-1:0]                lru_access_update_way;

    modport master (
        output req_valid, req_set, req_way, req_lock, cache_access_en, cache_fill_en,
        input  req_ack, req_reject, init_done, lru_access_en, lru_access_set, lru_lock_en,
               lru_lock_value, lru_access_update_en, lru_access_update_way
    );

    modport slave (
        input  req_valid, req_set, req_way, req_lock, cache_access_en, cache_fill_en,
        output req_ack, req_reject, init_done, lru_access_en, lru_access_set, lru_lock_en,
               lru_lock_value, lru_access_update_en, lru_access_update_way
    );
endinterface

// File: rtl/l2_cache_lock_ctrl.sv
// L2 way-lock controller: arbitrates lock/unlock requests onto the shared LRU access port,
// using only cycles the tag pipeline leaves idle. A per-set shadow of the lock bits lets it
// refuse locks that would pin every way and complete redundant requests without LRU traffic.
// After reset it sweeps every set/way to clear the LRU lock storage.
module l2_cache_lock_ctrl #(
    parameter int unsigned NUM_REQUESTERS  = 4,
    parameter int unsigned NUM_SETS        = 256,
    parameter int unsigned NUM_WAYS        = 4,
    parameter int unsigned SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    parameter int unsigned WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input logic                 clk,
    input logic                 reset,
    l2_cache_lock_ctrl_if.slave bus
);
    localparam int unsigned REQ_INDEX_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int unsigned CNT_WIDTH       = WAY_INDEX_WIDTH + 1;
    localparam logic [SET_INDEX_WIDTH-1:0] SET_MAX = SET_INDEX_WIDTH'(NUM_SETS - 1);
    localparam logic [WAY_INDEX_WIDTH-1:0] WAY_MAX = WAY_INDEX_WIDTH'(NUM_WAYS - 1);
    localparam logic [CNT_WIDTH-1:0]       FULL_CNT = CNT_WIDTH'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        StInitIssue,
        StInitUpdate,
        StIdle,
        StIssue,
        StUpdate
    } state_e;

    state_e                     state_q, state_d;
    logic [SET_INDEX_WIDTH-1:0] init_set_q, init_set_d;
    logic [WAY_INDEX_WIDTH-1:0] init_way_q, init_way_d;
    logic                       init_done_q, init_done_d;
    logic [REQ_INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_INDEX_WIDTH-1:0] grant_q, grant_d;
    logic [SET_INDEX_WIDTH-1:0] op_set_q, op_set_d;
    logic [WAY_INDEX_WIDTH-1:0] op_way_q, op_way_d;
    logic                       op_lock_q, op_lock_d;
    logic [NUM_WAYS-1:0]        shadow_q [NUM_SETS];
    logic                       shadow_we;

    logic                       grant_valid;
    logic [REQ_INDEX_WIDTH-1:0] grant_idx;
    logic [REQ_INDEX_WIDTH-1:0] cand_idx;
    int unsigned                cand;

    logic [NUM_WAYS-1:0]        cur_row;
    logic                       cur_bit;
    logic [CNT_WIDTH-1:0]       cur_count;
    logic                       redundant;
    logic                       at_limit;
    logic                       stall;

    logic                       access_en;
    logic [SET_INDEX_WIDTH-1:0] access_set;
    logic                       lock_en;
    logic                       lock_value;
    logic                       update_en;
    logic [WAY_INDEX_WIDTH-1:0] update_way;
    logic [NUM_REQUESTERS-1:0]  ack_vec;
    logic [NUM_REQUESTERS-1:0]  reject_vec;

    assign stall = bus.cache_access_en | bus.cache_fill_en;

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            cand     = (32'(rr_ptr_q) + k) % NUM_REQUESTERS;
            cand_idx = REQ_INDEX_WIDTH'(cand);
            if (!grant_valid && bus.req_valid[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Shadow lookup for the latched op: target bit, lock count, and the resulting decision.
    always_comb begin
        cur_row   = shadow_q[op_set_q];
        cur_bit   = cur_row[op_way_q];
        cur_count = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            cur_count = cur_count + CNT_WIDTH'(cur_row[w]);
        end
        redundant = (op_lock_q == cur_bit);
        at_limit  = op_lock_q && !cur_bit && (cur_count == FULL_CNT);
    end

    // Next-state and port drive for the init sweep and request sequencing.
    always_comb begin
        state_d     = state_q;
        init_set_d  = init_set_q;
        init_way_d  = init_way_q;
        init_done_d = init_done_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        op_set_d    = op_set_q;
        op_way_d    = op_way_q;
        op_lock_d   = op_lock_q;
        shadow_we   = 1'b0;
        access_en   = 1'b0;
        access_set  = '0;
        lock_en     = 1'b0;
        lock_value  = 1'b0;
        update_en   = 1'b0;
        update_way  = '0;
        ack_vec     = '0;
        reject_vec  = '0;

        unique case (state_q)
            StInitIssue: begin
                if (!stall) begin
                    access_en  = 1'b1;
                    lock_en    = 1'b1;
                    access_set = init_set_q;
                    state_d    = StInitUpdate;
                end
            end
            StInitUpdate: begin
                update_en  = 1'b1;
                update_way = init_way_q;
                state_d    = StInitIssue;
                if (init_way_q == WAY_MAX) begin
                    init_way_d = '0;
                    if (init_set_q == SET_MAX) begin
                        init_set_d  = '0;
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        init_set_d = init_set_q + SET_INDEX_WIDTH'(1);
                    end
                end else begin
                    init_way_d = init_way_q + WAY_INDEX_WIDTH'(1);
                end
            end
            StIdle: begin
                if (grant_valid) begin
                    grant_d   = grant_idx;
                    op_set_d  = bus.req_set[grant_idx*SET_INDEX_WIDTH +: SET_INDEX_WIDTH];
                    op_way_d  = bus.req_way[grant_idx*WAY_INDEX_WIDTH +: WAY_INDEX_WIDTH];
                    op_lock_d = bus.req_lock[grant_idx];
                    rr_ptr_d  = REQ_INDEX_WIDTH'((32'(grant_idx) + 1) % NUM_REQUESTERS);
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (redundant) begin
                    ack_vec[grant_q] = 1'b1;
                    state_d          = StIdle;
                end else if (at_limit) begin
                    reject_vec[grant_q] = 1'b1;
                    state_d             = StIdle;
                end else if (!stall) begin
                    access_en  = 1'b1;
                    lock_en    = 1'b1;
                    lock_value = op_lock_q;
                    access_set = op_set_q;
                    state_d    = StUpdate;
                end
            end
            StUpdate: begin
                update_en        = 1'b1;
                update_way       = op_way_q;
                shadow_we        = 1'b1;
                ack_vec[grant_q] = 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StInitIssue;
        endcase
    end

    // State, counters, latched op and shadow lock bits; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInitIssue;
            init_set_q  <= '0;
            init_way_q  <= '0;
            init_done_q <= 1'b0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            op_set_q    <= '0;
            op_way_q    <= '0;
            op_lock_q   <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                shadow_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_set_q  <= init_set_d;
            init_way_q  <= init_way_d;
            init_done_q <= init_done_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            op_set_q    <= op_set_d;
            op_way_q    <= op_way_d;
            op_lock_q   <= op_lock_d;
            if (shadow_we) begin
                shadow_q[op_set_q][op_way_q] <= op_lock_q;
            end
        end
    end

    // Outputs are held quiet while reset is asserted so an interrupted op never acks.
    always_comb begin
        bus.lru_access_en         = access_en & ~reset;
        bus.lru_access_set        = reset ? '0 : access_set;
        bus.lru_lock_en           = lock_en & ~reset;
        bus.lru_lock_value        = lock_value & ~reset;
        bus.lru_access_update_en  = update_en & ~reset;
        bus.lru_access_update_way = reset ? '0 : update_way;
        bus.req_ack               = reset ? '0 : ack_vec;
        bus.req_reject            = reset ? '0 : reject_vec;
        bus.init_done             = init_done_q & ~reset;
    end
endmodule

// File: tb/tb_l2_cache_lock_ctrl.sv
// Scoreboard bench for l2_cache_lock_ctrl: stimulus pushes expected port events (with the
// cycle they must appear in), a negedge monitor pops and compares every event the DUT shows.
module tb_l2_cache_lock_ctrl;
    localparam int NR = 4;
    localparam int NS = 4;
    localparam int NW = 4;
    localparam int SW = 2;
    localparam int WW = 2;

    localparam int K_ACCESS = 0;
    localparam int K_UPDATE = 1;
    localparam int K_ACK    = 2;
    localparam int K_REJECT = 3;
    localparam int K_INIT   = 4;

    localparam int O_ISSUE  = 0;
    localparam int O_ACK    = 1;
    localparam int O_REJECT = 2;

    typedef struct {
        int cyc;
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    logic prev_init = 1'b0;
    logic clk = 1'b0;
    logic reset = 1'b1;

    l2_cache_lock_ctrl_if #(
        .NUM_REQUESTERS (NR),
        .SET_INDEX_WIDTH(SW),
        .WAY_INDEX_WIDTH(WW)
    ) bus ();

    l2_cache_lock_ctrl #(
        .NUM_REQUESTERS (NR),
        .NUM_SETS       (NS),
        .NUM_WAYS       (NW),
        .SET_INDEX_WIDTH(SW),
        .WAY_INDEX_WIDTH(WW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input int k, input int a, input int b);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, want);
    endtask

    task automatic observe(input int k, input int a, input int b);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d cycle=%0d, required none",
                     k, a, b, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.a == a && e.b == b && e.cyc == cyc) n_pass++;
            else $display("FAIL event: got kind=%0d a=%0d b=%0d cycle=%0d, required kind=%0d a=%0d b=%0d cycle=%0d",
                          k, a, b, cyc, e.kind, e.a, e.b, e.cyc);
        end
    endtask

    // Monitor: every visible output action becomes an observed event.
    always @(negedge clk) begin
        if (bus.lru_access_en) begin
            check("access_during_pipeline_use", int'(bus.cache_access_en | bus.cache_fill_en), 0);
        end
        if (bus.init_done !== prev_init) begin
            observe(K_INIT, int'(bus.init_done), 0);
            prev_init = bus.init_done;
        end
        if (bus.lru_access_en)
            observe(K_ACCESS, int'(bus.lru_access_set), 2 * int'(bus.lru_lock_en) + int'(bus.lru_lock_value));
        if (bus.lru_access_update_en) observe(K_UPDATE, int'(bus.lru_access_update_way), 0);
        for (int i = 0; i < NR; i++) if (bus.req_ack[i]) observe(K_ACK, i, 0);
        for (int i = 0; i < NR; i++) if (bus.req_reject[i]) observe(K_REJECT, i, 0);
    end

    // Full unlock sweep starting at cycle base: set-major, way-minor, then init_done rises.
    task automatic expect_init(input int base);
        for (int k = 0; k < NS * NW; k++) begin
            push(base + 2 * k, K_ACCESS, k / NW, 2);
            push(base + 2 * k + 1, K_UPDATE, k % NW, 0);
        end
        push(base + 2 * NS * NW, K_INIT, 1, 0);
    endtask

    // One request from requester r; called right after a posedge with the DUT in IDLE.
    task automatic do_req(input int r, input int s, input int w, input int lock,
                          input int outcome, input int stall_n, input int fill);
        int c;
        bit done;
        c = cyc;
        bus.req_set[r*SW +: SW] = SW'(s);
        bus.req_way[r*WW +: WW] = WW'(w);
        bus.req_lock[r]         = (lock != 0);
        bus.req_valid[r]        = 1'b1;
        if (stall_n > 0) begin
            if (fill != 0) bus.cache_fill_en = 1'b1;
            else bus.cache_access_en = 1'b1;
        end
        if (outcome == O_ISSUE) begin
            push(c + 1 + stall_n, K_ACCESS, s, 2 + lock);
            push(c + 2 + stall_n, K_UPDATE, w, 0);
            push(c + 2 + stall_n, K_ACK, r, 0);
        end else if (outcome == O_ACK) begin
            push(c + 1, K_ACK, r, 0);
        end else begin
            push(c + 1, K_REJECT, r, 0);
        end
        if (stall_n > 0) begin
            repeat (stall_n + 1) @(posedge clk);
            #1;
            bus.cache_access_en = 1'b0;
            bus.cache_fill_en   = 1'b0;
        end
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (bus.req_ack[r] || bus.req_reject[r]) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL response_timeout: got no ack/reject for requester %0d, required one", r);
        end
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
    endtask

    initial begin
        int c;
        bus.req_valid       = '0;
        bus.req_set         = '0;
        bus.req_way         = '0;
        bus.req_lock        = '0;
        bus.cache_access_en = 1'b0;
        bus.cache_fill_en   = 1'b0;
        reset               = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_init_done", int'(bus.init_done), 0);
        check("reset_access_en", int'(bus.lru_access_en), 0);
        check("reset_update_en", int'(bus.lru_access_update_en), 0);
        check("reset_ack", int'(bus.req_ack), 0);

        // Init sweep with an idle pipeline.
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_init(cyc);
        repeat (33) @(posedge clk);
        #1;

        // Basic lock, then stalled issues (access stall, then fill stall).
        do_req(1, 2, 3, 1, O_ISSUE, 0, 0);
        do_req(1, 2, 2, 1, O_ISSUE, 3, 0);
        do_req(2, 2, 2, 0, O_ISSUE, 2, 1);

        // Lock limit on set 0.
        do_req(0, 0, 0, 1, O_ISSUE, 0, 0);
        do_req(0, 0, 1, 1, O_ISSUE, 0, 0);
        do_req(0, 0, 2, 1, O_ISSUE, 0, 0);
        do_req(3, 0, 3, 1, O_REJECT, 0, 0);
        do_req(2, 0, 1, 0, O_ISSUE, 0, 0);
        do_req(3, 0, 3, 1, O_ISSUE, 0, 0);
        do_req(1, 0, 1, 1, O_REJECT, 0, 0);

        // Redundant lock and unlock; the last grant leaves the pointer at 0.
        do_req(1, 1, 0, 1, O_ISSUE, 0, 0);
        do_req(0, 1, 2, 0, O_ACK, 0, 0);
        do_req(3, 1, 0, 1, O_ACK, 0, 0);

        // Fairness: all requesters continuously valid with redundant unlocks of set 3.
        c = cyc;
        for (int i = 0; i < NR; i++) begin
            bus.req_set[i*SW +: SW] = SW'(3);
            bus.req_way[i*WW +: WW] = WW'(i);
            bus.req_lock[i]         = 1'b0;
        end
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) push(c + 1 + 2 * i, K_ACK, i, 0);
        push(c + 9, K_ACK, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;

        // Reset while in UPDATE: no ack, init_done drops, sweep restarts at set 0 way 0.
        c = cyc;
        bus.req_set[1*SW +: SW] = SW'(3);
        bus.req_way[1*WW +: WW] = WW'(1);
        bus.req_lock[1]         = 1'b1;
        bus.req_valid[1]        = 1'b1;
        push(c + 1, K_ACCESS, 3, 3);
        repeat (2) @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.req_valid = '0;
        push(c + 2, K_INIT, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_init(cyc);
        repeat (33) @(posedge clk);
        #1;

        // Shadow was cleared by reset: old locks are gone, the abandoned lock never landed.
        do_req(0, 2, 3, 0, O_ACK, 0, 0);
        do_req(2, 3, 1, 0, O_ACK, 0, 0);
        do_req(1, 2, 3, 1, O_ISSUE, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_total++;
            $display("FAIL missing_event: got nothing, required kind=%0d a=%0d b=%0d cycle=%0d",
                     e.kind, e.a, e.b, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
